fault_injector: RTL and testbench

FAULT_INJECTOR -- requirements
Module: fault_injector

---
 rtl/fault_injector_pkg.sv | 29 ++
 rtl/fi_lfsr.sv | 21 ++
 rtl/fault_injector.sv | 173 +++++++++++++++++
 tb/tb_fault_injector.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_injector_pkg.sv
// Shared types and constants for the fault injector: mode/state encodings, LFSR taps, burst length.
package fault_injector_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_SINGLE   = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_BURST    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_BUILD  = 3'd2,
    S_INJECT = 3'd3,
    S_GAP    = 3'd4
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int          BURST_LEN = 4;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/fi_lfsr.sv
// 32-bit Galois LFSR with parametrised seed and taps; shifts right once per enabled cycle.
module fi_lfsr #(
  parameter logic [31:0] SEED = 32'hACE1_F00D,
  parameter logic [31:0] TAPS = 32'h8020_0003
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_state <= SEED;
    else if (i_en) r_state <= r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);
  end

  assign o_state = r_state;

endmodule

// File: rtl/fault_injector.sv
// Random multi-bit XOR fault injector (single / periodic / burst) with saturating inject and detect counters.
// Define FI_DETECT_LATENCY_EN to add latency_o: cycles from the last injection start to the next detection.
module fault_injector
  import fault_injector_pkg::*;
#(
  parameter int          NUM_TARGETS = 22,
  parameter int          DATA_WIDTH  = 32,
  parameter int          MAX_FLIPS   = 8,
  parameter logic [31:0] SEED        = 32'hACE1_F00D,
  localparam int         TW          = $clog2(NUM_TARGETS),
  localparam int         FW          = $clog2(MAX_FLIPS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            mode_i,
  input  logic                  trigger_i,
  input  logic [15:0]           period_i,
  input  logic [FW-1:0]         nflips_i,
  input  logic [7:0]            hold_i,
  input  logic                  err_detect_i,
  output logic                  inject_valid_o,
  output logic [TW-1:0]         inject_target_o,
  output logic [DATA_WIDTH-1:0] inject_mask_o,
  output logic                  busy_o,
  output logic [15:0]           inject_count_o,
  output logic [15:0]           detect_count_o
`ifdef FI_DETECT_LATENCY_EN
  ,
  output logic [15:0]           latency_o
`endif
);

  localparam int BW = $clog2(DATA_WIDTH);

  state_e                r_state, w_state_nxt;
  mode_e                 w_mode;
  logic [31:0]           w_lfsr;
  logic [15:0]           r_wait_cnt;
  logic [7:0]            r_hold_cnt;
  logic [2:0]            r_burst_cnt;
  logic [FW-1:0]         r_flips, w_flips_req;
  logic [DATA_WIDTH-1:0] r_mask, w_mask_nxt;
  logic [TW-1:0]         r_target;
  logic [15:0]           r_inj_cnt, r_det_cnt;
  logic                  r_err_q;
  logic                  w_start, w_wait_done, w_build_done, w_hold_done, w_burst_more;
  logic                  w_enter_build, w_enter_inject, w_det_rise, w_valid;
  logic                  w_unused_lfsr_hi;

  assign w_mode = mode_e'(mode_i);

  fi_lfsr #(.SEED(SEED), .TAPS(LFSR_TAPS)) u_lfsr (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_en    (r_state != S_IDLE),
    .o_state (w_lfsr)
  );
  assign w_unused_lfsr_hi = ^w_lfsr[31:16];

  assign w_start      = trigger_i && (w_mode == MODE_SINGLE || w_mode == MODE_BURST);
  assign w_wait_done  = (r_wait_cnt + 16'd1) >= period_i;
  assign w_flips_req  = (nflips_i > FW'(MAX_FLIPS)) ? FW'(MAX_FLIPS) : nflips_i;
  // A bit that is already set leaves the mask unchanged, so the build simply retries next cycle.
  assign w_mask_nxt   = r_mask | (DATA_WIDTH'(1) << w_lfsr[BW-1:0]);
  assign w_build_done = popcount64(64'(w_mask_nxt)) == 7'(r_flips);
  assign w_hold_done  = r_hold_cnt <= 8'd1;
  assign w_burst_more = (w_mode == MODE_BURST) && (r_burst_cnt < 3'(BURST_LEN - 1));
  assign w_det_rise   = err_detect_i && !r_err_q;

  assign w_enter_build  = (w_state_nxt == S_BUILD) && (r_state != S_BUILD);
  assign w_enter_inject = (r_state == S_BUILD) && (w_state_nxt == S_INJECT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mode == MODE_PERIODIC) w_state_nxt = S_WAIT;
        else if (w_start)            w_state_nxt = S_BUILD;
      end
      S_WAIT: begin
        if (w_mode != MODE_PERIODIC) w_state_nxt = S_IDLE;
        else if (w_wait_done)        w_state_nxt = S_BUILD;
      end
      S_BUILD: begin
        if (r_flips == '0)     w_state_nxt = S_GAP;
        else if (w_build_done) w_state_nxt = S_INJECT;
      end
      S_INJECT: begin
        if (w_hold_done) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_burst_more)                 w_state_nxt = S_BUILD;
        else if (w_mode == MODE_PERIODIC) w_state_nxt = S_WAIT;
        else                              w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_valid = (r_state == S_INJECT);
    busy_o  = (r_state != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_burst_cnt <= '0;
      r_flips     <= '0;
      r_mask      <= '0;
      r_target    <= '0;
      r_inj_cnt   <= '0;
      r_det_cnt   <= '0;
      r_err_q     <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 16'd1 : 16'd0;

      if (w_enter_build) begin
        r_target <= TW'(w_lfsr[15:0] % 16'(NUM_TARGETS));
        r_mask   <= '0;
        r_flips  <= w_flips_req;
      end else if (r_state == S_BUILD && r_flips != '0) begin
        r_mask <= w_mask_nxt;
      end

      if (w_enter_inject)          r_hold_cnt <= (hold_i == 8'd0) ? 8'd1 : hold_i;
      else if (r_state == S_INJECT) r_hold_cnt <= r_hold_cnt - 8'd1;

      if (r_state == S_IDLE)     r_burst_cnt <= '0;
      else if (r_state == S_GAP) r_burst_cnt <= r_burst_cnt + 3'd1;

      r_err_q <= err_detect_i;
      if (w_enter_inject && r_inj_cnt != 16'hFFFF) r_inj_cnt <= r_inj_cnt + 16'd1;
      if (w_det_rise && r_det_cnt != 16'hFFFF)     r_det_cnt <= r_det_cnt + 16'd1;
    end
  end

  assign inject_valid_o  = w_valid;
  assign inject_target_o = r_target;
  assign inject_mask_o   = w_valid ? r_mask : '0;
  assign inject_count_o  = r_inj_cnt;
  assign detect_count_o  = r_det_cnt;

`ifdef FI_DETECT_LATENCY_EN
  logic [15:0] r_lat_cnt, r_latency;
  logic        r_injected;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lat_cnt  <= '0;
      r_latency  <= 16'hFFFF;
      r_injected <= 1'b0;
    end else begin
      if (w_enter_inject) begin
        r_lat_cnt  <= '0;
        r_injected <= 1'b1;
      end else if (r_lat_cnt != 16'hFFFF) begin
        r_lat_cnt <= r_lat_cnt + 16'd1;
      end
      if (w_det_rise && r_injected) r_latency <= r_lat_cnt;
    end
  end

  assign latency_o = r_latency;
`endif

endmodule

// File: tb/tb_fault_injector.sv
// Directed bench for fault_injector: scoreboard of expected injections checked by a negedge monitor.
module tb_fault_injector;

  localparam logic [31:0] SEED_C = 32'hACE1_F00D;
  localparam logic [31:0] TAPS_C = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        trigger;
  logic [15:0] period;
  logic [3:0]  nflips;
  logic [7:0]  hold;
  logic        err;
  logic        inject_valid_o;
  logic [4:0]  inject_target_o;
  logic [31:0] inject_mask_o;
  logic        busy_o;
  logic [15:0] inject_count_o;
  logic [15:0] detect_count_o;

  fault_injector dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .mode_i          (mode),
    .trigger_i       (trigger),
    .period_i        (period),
    .nflips_i        (nflips),
    .hold_i          (hold),
    .err_detect_i    (err),
    .inject_valid_o  (inject_valid_o),
    .inject_target_o (inject_target_o),
    .inject_mask_o   (inject_mask_o),
    .busy_o          (busy_o),
    .inject_count_o  (inject_count_o),
    .detect_count_o  (detect_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exact;
    logic [4:0]  tgt;
    logic [31:0] mask;
    int          pop;
    int          hold;
  } exp_t;

  exp_t sb[$];
  int   start_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS_C) : (s >> 1);
  endfunction

  // Expected target/mask/build length for an injection launched from IDLE straight after reset.
  task automatic model_build(input int flips, output logic [4:0] tgt, output logic [31:0] mask,
                             output int bcyc);
    logic [31:0] s;
    s    = SEED_C;
    tgt  = 5'(s[15:0] % 16'd22);
    mask = '0;
    bcyc = (flips == 0) ? 1 : 0;
    while ($countones(mask) < flips) begin
      mask = mask | (32'd1 << s[4:0]);
      s    = lstep(s);
      bcyc++;
    end
  endtask

  task automatic push_exact(input int req_flips, input int h, output int bcyc);
    logic [4:0]  t;
    logic [31:0] m;
    int          f;
    f = (req_flips > 8) ? 8 : req_flips;
    model_build(f, t, m, bcyc);
    sb.push_back('{1'b1, t, m, f, (h == 0) ? 1 : h});
  endtask

  task automatic push_loose(input int f, input int h);
    sb.push_back('{1'b0, 5'd0, 32'd0, f, h});
  endtask

  // Monitor: pops one expectation per injection and checks mask, target, stability and hold length.
  logic        pv = 1'b0;
  int          vlen;
  logic [4:0]  t0;
  logic [31:0] m0;
  exp_t        cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (inject_valid_o && !pv) begin
        start_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_inject", 1, 0);
        end else begin
          cur = sb.pop_front();
          if (cur.exact) begin
            chk("target", inject_target_o, cur.tgt);
            chk("mask", inject_mask_o, cur.mask);
          end
          chk("mask_popcount", $countones(inject_mask_o), cur.pop);
          chk("target_range", inject_target_o < 5'd22, 1);
        end
        t0   = inject_target_o;
        m0   = inject_mask_o;
        vlen = 1;
      end else if (inject_valid_o) begin
        vlen++;
        chk("stable", {inject_target_o, inject_mask_o}, {t0, m0});
      end
      if (!inject_valid_o && pv) chk("hold_len", vlen, cur.hold);
      pv = inject_valid_o;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    mode = 2'd0; trigger = 1'b0; err = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_trigger();
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!inject_valid_o && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy_o && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", busy_o, 0);
  endtask

  task automatic pulse_err();
    @(negedge clk); err = 1'b1;
    @(negedge clk); @(negedge clk); err = 1'b0;
  endtask

  initial begin
    int b, n, k;
    rst_n = 1'b0; mode = 2'd0; trigger = 1'b0; period = 16'd0;
    nflips = 4'd0; hold = 8'd0; err = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_valid", inject_valid_o, 0);
    chk("rst_mask", inject_mask_o, 0);
    chk("rst_target", inject_target_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_inj_cnt", inject_count_o, 0);
    chk("rst_det_cnt", detect_count_o, 0);
    #1 rst_n = 1'b1;

    // SINGLE, one flip, hold 1
    mode = 2'd1; nflips = 4'd1; hold = 8'd1;
    push_exact(1, 1, b);
    pulse_trigger();
    wait_valid(n);
    chk("single1_start_lat", n, b + 1);
    wait_idle(k);
    chk("single1_inj_cnt", inject_count_o, 1);

    // SINGLE, five flips, hold 3; a trigger during the injection is ignored
    do_reset();
    mode = 2'd1; nflips = 4'd5; hold = 8'd3;
    push_exact(5, 3, b);
    pulse_trigger();
    wait_valid(n);
    chk("single5_start_lat", n, b + 1);
    pulse_trigger();
    wait_idle(k);
    repeat (5) @(negedge clk);
    chk("busy_trigger_ignored", busy_o, 0);
    chk("single5_inj_cnt", inject_count_o, 1);

    // nflips above MAX_FLIPS clamps to 8; three detect pulses
    do_reset();
    mode = 2'd1; nflips = 4'd15; hold = 8'd2;
    push_exact(15, 2, b);
    pulse_trigger();
    wait_valid(n);
    chk("clamp_start_lat", n, b + 1);
    wait_idle(k);
    repeat (3) pulse_err();
    @(negedge clk);
    chk("det_cnt_3", detect_count_o, 3);

    // BURST with zero flips: four silent rounds of BUILD+GAP
    mode = 2'd3; nflips = 4'd0; hold = 8'd1;
    pulse_trigger();
    wait_idle(k);
    chk("burst0_busy_len", k, 8);
    chk("burst0_inj_cnt", inject_count_o, 1);

    // BURST with two flips: four injections
    nflips = 4'd2; hold = 8'd2;
    repeat (4) push_loose(2, 2);
    pulse_trigger();
    wait_idle(k);
    mode = 2'd0;
    chk("burst2_inj_cnt", inject_count_o, 5);
    chk("burst2_sb_empty", sb.size(), 0);

    // PERIODIC 100 over 1000 cycles: starts every 100+1+1+1 cycles
    do_reset();
    period = 16'd100; nflips = 4'd1; hold = 8'd1;
    repeat (9) push_loose(1, 1);
    start_cyc.delete();
    @(negedge clk); mode = 2'd2;
    repeat (1000) @(negedge clk);
    mode = 2'd0;
    chk("periodic_starts", start_cyc.size(), 9);
    for (int i = 1; i < start_cyc.size(); i++)
      chk("periodic_spacing", start_cyc[i] - start_cyc[i-1], 103);
    chk("periodic_inj_cnt", inject_count_o, 9);
    chk("periodic_sb_empty", sb.size(), 0);
    wait_idle(k);

    // Reset mid-INJECT clears outputs at once; next trigger repeats the first pattern
    do_reset();
    mode = 2'd1; nflips = 4'd1; hold = 8'd10;
    pulse_err();
    chk("pre_rst_det_cnt", detect_count_o, 1);
    push_exact(1, 10, b);
    pulse_trigger();
    wait_valid(n);
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", inject_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", inject_valid_o, 0);
    chk("midrst_mask", inject_mask_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_inj_cnt", inject_count_o, 0);
    chk("midrst_det_cnt", detect_count_o, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    hold = 8'd1;
    push_exact(1, 1, b);
    pulse_trigger();
    wait_valid(n);
    chk("rerun_start_lat", n, b + 1);
    wait_idle(k);
    chk("rerun_inj_cnt", inject_count_o, 1);

    // Mode OFF during a PERIODIC injection: hold completes, then IDLE
    period = 16'd5; nflips = 4'd1; hold = 8'd4;
    push_loose(1, 4);
    @(negedge clk); mode = 2'd2;
    wait_valid(n);
    chk("off_mid_started", inject_valid_o, 1);
    mode = 2'd0;
    wait_idle(k);
    repeat (20) @(negedge clk);
    chk("off_mid_busy", busy_o, 0);
    chk("off_mid_inj_cnt", inject_count_o, 2);
    chk("off_mid_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
